// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencing controller for the EX stage: holds HI/LO, models
// the fixed mult/div latency with a down-counter, and requests pipeline stalls.
module md_unit_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        busy,
    output logic        stall_req,
    output logic        dbg_run
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             res_wr_q, res_wr_d;

    logic             accept, is_md, is_div;
    logic [63:0]      prod_s, prod_u;
    logic [31:0]      udiv_b, sdiv_b, q_u, r_u, q_s, r_s;
    logic [31:0]      calc_hi, calc_lo;
    logic             calc_wr, div_ovf;
    logic [CNT_W-1:0] load;

    // Arithmetic datapath: results are computed at acceptance and parked
    // until the modelled latency expires.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'h0, A} * {32'h0, B};
        div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        udiv_b  = (B == 32'h0) ? 32'h1 : B;
        // Forcing the divisor to 1 on overflow yields the defined result
        // (quotient = dividend, remainder = 0).
        sdiv_b  = ((B == 32'h0) || div_ovf) ? 32'h1 : B;
        q_u     = A / udiv_b;
        r_u     = A % udiv_b;
        q_s     = $signed(A) / $signed(sdiv_b);
        r_s     = $signed(A) % $signed(sdiv_b);
        calc_hi = 32'h0;
        calc_lo = 32'h0;
        case (op[1:0])
            2'd0:    {calc_hi, calc_lo} = prod_s;
            2'd1:    {calc_hi, calc_lo} = prod_u;
            2'd2:    begin calc_hi = r_s; calc_lo = q_s; end
            default: begin calc_hi = r_u; calc_lo = q_u; end
        endcase
        calc_wr = !(op[1] && (B == 32'h0));
    end

    always_comb begin
        is_md  = (op <= 3'd3);
        is_div = op[1];
        accept = start && !flush && (state_q == IDLE) && (op <= 3'd5);
        load   = is_div ? DIV_LOAD : MULT_LOAD;

        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_md) begin
                        res_hi_d = calc_hi;
                        res_lo_d = calc_lo;
                        res_wr_d = calc_wr;
                        cnt_d    = load;
                        if (load == '0) begin
                            if (calc_wr) begin
                                hi_d = calc_hi;
                                lo_d = calc_lo;
                            end
                        end else begin
                            state_d = RUN;
                        end
                    end else if (op == 3'd4) begin
                        hi_d = A;
                    end else begin
                        lo_d = A;
                    end
                end
            end
            RUN: begin
                // flush is deliberately ignored here: the issuing op is committed.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = IDLE;
                    if (res_wr_q) begin
                        hi_d = res_hi_q;
                        lo_d = res_lo_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            res_hi_q <= 32'h0;
            res_lo_q <= 32'h0;
            res_wr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = (state_q == RUN);
    assign dbg_run   = (state_q == RUN);
    assign stall_req = busy || (start && !flush && (op <= 3'd3) && (state_q == IDLE));

endmodule
